imm_ext_ctrl: RTL and testbench

Decode-stage immediate-operand controller for the MIPS datapath. It takes the opcode and 16-bit immediate from the fetched instruction and selects the extension mode: sign, zero or upper (LUI). It produces the 32-bit operand through a registered, back-pressurable two-entry skid pipeline and feeds the ID/EX boundary. It honours stall (via ready) and flush from the hazard logic.

---
 rtl/imm_ext_pkg.sv | 33 +++
 rtl/imm_ext_ctrl_if.sv | 33 +++
 rtl/imm_ext_unit.sv | 39 +++
 rtl/imm_ext_ctrl.sv | 134 +++++++++++++
 tb/tb_imm_ext_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : imm_ext_pkg
//  Description : Shared widths, opcode constants, extension modes and
//                controller states for the immediate-extension controller.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_ext_pkg;

    localparam int PKG_IMM_W  = 16;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_OPC_W  = 6;

    // Opcodes that select a non-default extension
    localparam logic [5:0] OPC_ANDI = 6'h0C;
    localparam logic [5:0] OPC_ORI  = 6'h0D;
    localparam logic [5:0] OPC_XORI = 6'h0E;
    localparam logic [5:0] OPC_LUI  = 6'h0F;

    typedef enum logic [1:0] {
        MODE_SIGN  = 2'd0,
        MODE_ZERO  = 2'd1,
        MODE_UPPER = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imm_ext_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : imm_ext_ctrl_if
//  Description : Input (instruction fields) and output (extended operand)
//                valid/ready handshakes of the immediate controller.
//                master = producer/consumer side, slave = controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface imm_ext_ctrl_if #(
    parameter int IMM_W  = imm_ext_pkg::PKG_IMM_W,
    parameter int DATA_W = imm_ext_pkg::PKG_DATA_W,
    parameter int OPC_W  = imm_ext_pkg::PKG_OPC_W
) ();
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode;
    logic [IMM_W-1:0]  in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [1:0]        out_mode;

    modport master (
        output in_valid, in_opcode, in_imm, out_ready,
        input  in_ready, out_valid, out_imm, out_mode
    );

    modport slave (
        input  in_valid, in_opcode, in_imm, out_ready,
        output in_ready, out_valid, out_imm, out_mode
    );
endinterface
`default_nettype wire

// File: rtl/imm_ext_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_unit
//  Description : Combinational opcode/immediate decode into extension mode
//                and extended operand (sign, zero or upper-half placement).
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_unit #(
    parameter int IMM_W  = imm_ext_pkg::PKG_IMM_W,
    parameter int DATA_W = imm_ext_pkg::PKG_DATA_W,
    parameter int OPC_W  = imm_ext_pkg::PKG_OPC_W
) (
    input  wire logic [OPC_W-1:0]  opcode_i,
    input  wire logic [IMM_W-1:0]  imm_i,
    output imm_ext_pkg::mode_t     mode_o,
    output logic      [DATA_W-1:0] ext_o
);
    import imm_ext_pkg::*;

    // Logical-immediate ops zero-extend, LUI places imm in the upper half,
    // everything else (arith, loads/stores, branches) sign-extends.
    always_comb begin
        mode_o = MODE_SIGN;
        ext_o  = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        case (opcode_i)
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                mode_o = MODE_ZERO;
                ext_o  = {{(DATA_W-IMM_W){1'b0}}, imm_i};
            end
            OPC_LUI: begin
                mode_o = MODE_UPPER;
                ext_o  = {imm_i, {(DATA_W-IMM_W){1'b0}}};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_ctrl
//  Description : Decode-stage immediate controller. Extends the immediate on
//                the input side and buffers it in a two-entry skid pipeline
//                (main + skid register) towards the ID/EX boundary.
//                Optional: IMM_EXT_STATS_EN adds stat_neg_cnt, a saturating
//                count of delivered negative sign-extended operands.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_ctrl #(
    parameter int IMM_W  = imm_ext_pkg::PKG_IMM_W,
    parameter int DATA_W = imm_ext_pkg::PKG_DATA_W,
    parameter int OPC_W  = imm_ext_pkg::PKG_OPC_W
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      flush,
    imm_ext_ctrl_if.slave  bus
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [15:0]    stat_neg_cnt
`endif
);
    import imm_ext_pkg::*;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_imm_q, main_imm_d;
    mode_t             main_mode_q, main_mode_d;
    logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
    mode_t             skid_mode_q, skid_mode_d;

    mode_t             new_mode;
    logic [DATA_W-1:0] new_ext;
    logic              in_xfer;
    logic              out_xfer;

    imm_ext_unit #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_unit (
        .opcode_i (bus.in_opcode),
        .imm_i    (bus.in_imm),
        .mode_o   (new_mode),
        .ext_o    (new_ext)
    );

    // Ready depends only on registered state, never on out_ready
    assign bus.in_ready  = (state_q != ST_FULL) & ~rst;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_imm   = main_imm_q;
    assign bus.out_mode  = main_mode_q;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    // State and both storage entries; reset discards everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_imm_q  <= '0;
            main_mode_q <= MODE_SIGN;
            skid_imm_q  <= '0;
            skid_mode_q <= MODE_SIGN;
        end else begin
            state_q     <= state_d;
            main_imm_q  <= main_imm_d;
            main_mode_q <= main_mode_d;
            skid_imm_q  <= skid_imm_d;
            skid_mode_q <= skid_mode_d;
        end
    end

    // Next state and data movement; flush overrides every other event
    always_comb begin
        state_d     = state_q;
        main_imm_d  = main_imm_q;
        main_mode_d = main_mode_q;
        skid_imm_d  = skid_imm_q;
        skid_mode_d = skid_mode_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d     = ST_ONE;
                    main_imm_d  = new_ext;
                    main_mode_d = new_mode;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_imm_d  = new_ext;
                    main_mode_d = new_mode;
                end else if (in_xfer) begin
                    state_d     = ST_FULL;
                    skid_imm_d  = new_ext;
                    skid_mode_d = new_mode;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d     = ST_ONE;
                    main_imm_d  = skid_imm_q;
                    main_mode_d = skid_mode_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

`ifdef IMM_EXT_STATS_EN
    logic [15:0] neg_cnt_q;

    // Count delivered negative sign-extended operands, saturating; flush
    // does not clear it because a flushed-cycle delivery still happened
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_cnt_q <= '0;
        end else if (out_xfer && (main_mode_q == MODE_SIGN) &&
                     main_imm_q[DATA_W-1] && (neg_cnt_q != 16'hFFFF)) begin
            neg_cnt_q <= neg_cnt_q + 16'd1;
        end
    end

    assign stat_neg_cnt = neg_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_ctrl
//  Description : Self-checking bench for imm_ext_ctrl: queue-based reference
//                model, per-cycle compare, directed literal checks and a
//                randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_ext_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_ext_ctrl_if bus ();

`ifdef IMM_EXT_STATS_EN
    logic [15:0] stat_neg_cnt;
`endif

    imm_ext_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus)
`ifdef IMM_EXT_STATS_EN
        ,
        .stat_neg_cnt (stat_neg_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] imm;
        logic [1:0]  mode;
    } exp_t;

    exp_t        mq[$];
    int unsigned m_neg;

    function automatic exp_t ref_ext(input logic [5:0] opc, input logic [15:0] imm);
        exp_t        e;
        int unsigned v;
        v = imm;
        if (opc == 6'd12 || opc == 6'd13 || opc == 6'd14) begin
            e.mode = 2'd1;
            e.imm  = v;
        end else if (opc == 6'd15) begin
            e.mode = 2'd2;
            e.imm  = v * 65536;
        end else begin
            e.mode = 2'd0;
            e.imm  = (v >= 32768) ? (v + 32'hFFFF_0000) : v;
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit in_x;
        bit out_x;
        if (rst) begin
            mq.delete();
            m_neg = 0;
        end else begin
            in_x  = bus.in_valid && (mq.size() < 2);
            out_x = (mq.size() > 0) && bus.out_ready;
            if (out_x && mq[0].mode == 2'd0 && mq[0].imm[31] && m_neg < 65535) m_neg++;
            if (flush) begin
                mq.delete();
            end else begin
                if (out_x) void'(mq.pop_front());
                if (in_x) mq.push_back(ref_ext(bus.in_opcode, bus.in_imm));
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
            check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("out_imm", bus.out_imm, mq[0].imm);
                check("out_mode", 32'(bus.out_mode), 32'(mq[0].mode));
            end
`ifdef IMM_EXT_STATS_EN
            check("stat_neg_cnt", 32'(stat_neg_cnt), m_neg);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic send(input logic [5:0] opc, input logic [15:0] imm);
        tick();
        bus.in_valid  = 1'b1;
        bus.in_opcode = opc;
        bus.in_imm    = imm;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          ready_pct;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_imm", bus.out_imm, 32'd0);
        check("rst_out_mode", 32'(bus.out_mode), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        at_neg();
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Sign / zero / upper modes
        bus.out_ready = 1'b1;
        send(6'h08, 16'hC568);
        at_neg();
        check("addi_neg", bus.out_imm, 32'hFFFF_C568);
        check("addi_neg_mode", 32'(bus.out_mode), 32'd0);
        send(6'h08, 16'h007A);
        at_neg();
        check("addi_pos", bus.out_imm, 32'h0000_007A);
        send(6'h0D, 16'hFF6A);
        at_neg();
        check("ori", bus.out_imm, 32'h0000_FF6A);
        check("ori_mode", 32'(bus.out_mode), 32'd1);
        send(6'h0F, 16'h1234);
        at_neg();
        check("lui", bus.out_imm, 32'h1234_0000);
        check("lui_mode", 32'(bus.out_mode), 32'd2);

        // Backpressure: two beats fill the pipe, third waits upstream
        tick();
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'h08;
        bus.in_imm    = 16'h028A;
        tick();
        bus.in_imm    = 16'h012C;
        tick();
        bus.in_imm    = 16'h3A98;
        at_neg();
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_hold0", bus.out_imm, 32'h0000_028A);
        tick();
        at_neg();
        check("bp_hold1", bus.out_imm, 32'h0000_028A);
        tick();
        bus.out_ready = 1'b1;
        at_neg();
        check("bp_drain0", bus.out_imm, 32'h0000_028A);
        tick();
        at_neg();
        check("bp_drain1", bus.out_imm, 32'h0000_012C);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        at_neg();
        check("bp_drain2", bus.out_imm, 32'h0000_3A98);
        check("bp_drain2_valid", 32'(bus.out_valid), 32'd1);

        // Flush while full with an incoming beat
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'h08;
        bus.in_imm    = 16'h1111;
        tick();
        bus.in_imm    = 16'h2222;
        tick();
        bus.in_imm    = 16'h3333;
        flush         = 1'b1;
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        at_neg();
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        at_neg();
        check("flush_no_delivery", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with two beats buffered
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'h0F;
        bus.in_imm    = 16'hABCD;
        tick();
        bus.in_imm    = 16'h5555;
        tick();
        bus.in_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_imm", bus.out_imm, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        at_neg();
        check("in_ready_after_rst2", 32'(bus.in_ready), 32'd1);

        // Negative-operand statistics
        bus.out_ready = 1'b1;
        send(6'h08, 16'hFF6A);
        send(6'h08, 16'hC568);
        send(6'h0D, 16'hFF6A);
        tick();
        tick();
        at_neg();
`ifdef IMM_EXT_STATS_EN
        check("stat_neg_cnt_lit", 32'(stat_neg_cnt), 32'd2);
`endif
        check("stats_drained", 32'(bus.out_valid), 32'd0);

        // Randomized traffic with varying downstream stall pressure
        ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 200 == 0) ready_pct = $urandom_range(10, 100);
            r = $urandom;
            bus.in_valid = (r[1:0] != 2'b00);
            if (r[2]) bus.in_opcode = 6'(8 + r[5:3]);
            else      bus.in_opcode = r[11:6];
            r = $urandom;
            bus.in_imm    = r[15:0];
            bus.out_ready = ($urandom_range(1, 100) <= ready_pct);
            flush         = ($urandom_range(0, 19) == 0);
        end
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        at_neg();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
